// File: rtl/ex_cond_flags.sv
// Execute-stage NZCV flag register, ARM condition evaluation and gating of
// write/branch controls into the Execute->Memory register. Optional counters: COND_STATS_EN.
module ex_cond_flags #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush_e,
  input  logic        valid_e,
  input  logic [3:0]  cond_e,
  input  logic [1:0]  flag_w_e,
  input  logic        reg_w_e,
  input  logic        mem_w_e,
  input  logic        pcs_e,
  input  logic        no_write_e,
  input  logic [3:0]  alu_flags_e,
  output logic        cond_ex_e,
  output logic        pc_src_e,
  output logic [3:0]  flags_q,
  output logic        reg_write_m,
  output logic        mem_write_m,
  output logic        pc_src_m,
  output logic        undef_m,
  output logic [15:0] exec_cnt,
  output logic [15:0] squash_cnt
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_t;

  logic flag_n, flag_z, flag_c, flag_v, ge;
  logic pass;
  logic live;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];
  assign ge     = (flag_n == flag_v);

  // Condition is always judged against the architectural flags, never the ALU's.
  always_comb begin
    pass = 1'b0;
    unique case (cond_t'(cond_e))
      CC_EQ: pass = flag_z;
      CC_NE: pass = ~flag_z;
      CC_CS: pass = flag_c;
      CC_CC: pass = ~flag_c;
      CC_MI: pass = flag_n;
      CC_PL: pass = ~flag_n;
      CC_VS: pass = flag_v;
      CC_VC: pass = ~flag_v;
      CC_HI: pass = flag_c & ~flag_z;
      CC_LS: pass = ~flag_c | flag_z;
      CC_GE: pass = ge;
      CC_LT: pass = ~ge;
      CC_GT: pass = ~flag_z & ge;
      CC_LE: pass = flag_z | ~ge;
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

  assign cond_ex_e = valid_e & pass;
  assign pc_src_e  = pcs_e & cond_ex_e & ~flush_e;
  assign live      = en & valid_e & ~flush_e;

  // N,Z and C,V are written independently under their own enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= RESET_FLAGS;
    end else if (live && cond_ex_e) begin
      if (flag_w_e[1]) flags_q[3:2] <= alu_flags_e[3:2];
      if (flag_w_e[0]) flags_q[1:0] <= alu_flags_e[1:0];
    end
  end

  // Flush bubbles the Memory-side controls even while the stage is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_m <= 1'b0;
      mem_write_m <= 1'b0;
      pc_src_m    <= 1'b0;
      undef_m     <= 1'b0;
    end else if (flush_e) begin
      reg_write_m <= 1'b0;
      mem_write_m <= 1'b0;
      pc_src_m    <= 1'b0;
      undef_m     <= 1'b0;
    end else if (en) begin
      reg_write_m <= reg_w_e & ~no_write_e & cond_ex_e;
      mem_write_m <= mem_w_e & cond_ex_e;
      pc_src_m    <= pcs_e & cond_ex_e;
      undef_m     <= valid_e & (cond_e == 4'b1111);
    end
  end

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] squash_q;

  // Saturating counts of live instructions that executed or were predicated off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else if (live) begin
      if (cond_ex_e) begin
        if (exec_q != {CNT_W{1'b1}}) exec_q <= exec_q + CNT_W'(1);
      end else begin
        if (squash_q != {CNT_W{1'b1}}) squash_q <= squash_q + CNT_W'(1);
      end
    end
  end

  assign exec_cnt   = exec_q;
  assign squash_cnt = squash_q;
`else
  assign exec_cnt   = '0;
  assign squash_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_cond_flags.sv
// Self-checking bench for ex_cond_flags: behavioural NZCV/condition model compared
// every cycle, plus directed literal checks and a randomized phase.
module tb_ex_cond_flags;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0, flush_e = 1'b0, valid_e = 1'b0;
  logic [3:0]  cond_e = 4'h0;
  logic [1:0]  flag_w_e = 2'b00;
  logic        reg_w_e = 1'b0, mem_w_e = 1'b0, pcs_e = 1'b0, no_write_e = 1'b0;
  logic [3:0]  alu_flags_e = 4'h0;
  logic        cond_ex_e, pc_src_e;
  logic [3:0]  flags_q;
  logic        reg_write_m, mem_write_m, pc_src_m, undef_m;
  logic [15:0] exec_cnt, squash_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  ex_cond_flags dut (
    .clk(clk), .reset(reset), .en(en), .flush_e(flush_e), .valid_e(valid_e),
    .cond_e(cond_e), .flag_w_e(flag_w_e), .reg_w_e(reg_w_e), .mem_w_e(mem_w_e),
    .pcs_e(pcs_e), .no_write_e(no_write_e), .alu_flags_e(alu_flags_e),
    .cond_ex_e(cond_ex_e), .pc_src_e(pc_src_e), .flags_q(flags_q),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .pc_src_m(pc_src_m),
    .undef_m(undef_m), .exec_cnt(exec_cnt), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  // ARM conditions come in complementary pairs: cond[3:1] picks the test, cond[0] inverts it.
  function automatic bit model_pass(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c == 4'b1110);
    endcase
    return base ^ c[0];
  endfunction

  bit [3:0] m_flags;
  bit       m_rw, m_mw, m_pc, m_ud;
  int       m_exec, m_squash;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_flags = 4'b0000;
      {m_rw, m_mw, m_pc, m_ud} = 4'b0000;
      m_exec = 0; m_squash = 0;
    end else begin
      bit ok, lv;
      ok = valid_e && model_pass(cond_e, m_flags);
      lv = en && valid_e && !flush_e;
      if (flush_e) {m_rw, m_mw, m_pc, m_ud} = 4'b0000;
      else if (en) begin
        m_rw = reg_w_e && !no_write_e && ok;
        m_mw = mem_w_e && ok;
        m_pc = pcs_e && ok;
        m_ud = valid_e && (cond_e == 4'hF);
      end
      if (lv && ok) begin
        if (flag_w_e[1]) m_flags[3:2] = alu_flags_e[3:2];
        if (flag_w_e[0]) m_flags[1:0] = alu_flags_e[1:0];
      end
      if (lv &&  ok && m_exec   < 65535) m_exec++;
      if (lv && !ok && m_squash < 65535) m_squash++;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit ok;
      int ee, es;
      ok = valid_e && model_pass(cond_e, m_flags);
`ifdef COND_STATS_EN
      ee = m_exec; es = m_squash;
`else
      ee = 0; es = 0;
`endif
      chk("m_flags",     16'(flags_q),     16'(m_flags));
      chk("m_reg_write", 16'(reg_write_m), 16'(m_rw));
      chk("m_mem_write", 16'(mem_write_m), 16'(m_mw));
      chk("m_pc_src",    16'(pc_src_m),    16'(m_pc));
      chk("m_undef",     16'(undef_m),     16'(m_ud));
      chk("m_cond_ex",   16'(cond_ex_e),   16'(ok));
      chk("m_pc_src_e",  16'(pc_src_e),    16'(pcs_e && ok && !flush_e));
      chk("m_exec_cnt",  exec_cnt,   16'(ee));
      chk("m_squash_cnt", squash_cnt, 16'(es));
    end
  end

  task automatic issue(input bit e, input bit f, input bit v, input bit [3:0] c,
                       input bit [1:0] fw, input bit rw, input bit mw, input bit ps,
                       input bit nw, input bit [3:0] af);
    en = e; flush_e = f; valid_e = v; cond_e = c; flag_w_e = fw;
    reg_w_e = rw; mem_w_e = mw; pcs_e = ps; no_write_e = nw; alu_flags_e = af;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Set flags through an AL instruction writing both fields.
  task automatic set_flags(input bit [3:0] f);
    issue(1, 0, 1, 4'hE, 2'b11, 0, 0, 0, 0, f);
    tick();
  endtask

  logic [15:0] sq0;

  initial begin
    #1 reset = 1'b1;
    issue(0, 0, 0, 4'h0, 2'b00, 0, 0, 0, 0, 4'h0);
    chk_en = 1'b1;
    tick(); tick();
    chk("reset_flags", 16'(flags_q), 16'h0);
    chk("reset_regw",  16'(reg_write_m), 16'h0);
    reset = 1'b0;

    // CMP setting Z, then EQ / NE consumers
    issue(1, 0, 1, 4'hE, 2'b11, 0, 0, 0, 1, 4'b0100); tick();
    chk("cmp_flags", 16'(flags_q), 16'h4);
    chk("cmp_regw",  16'(reg_write_m), 16'h0);
    issue(1, 0, 1, 4'h0, 2'b00, 1, 0, 0, 0, 4'h0);
    chk("eq_cond_ex", 16'(cond_ex_e), 16'h1);
    tick();
    chk("eq_regw", 16'(reg_write_m), 16'h1);
    issue(1, 0, 1, 4'h1, 2'b00, 1, 0, 0, 0, 4'h0); tick();
    chk("ne_regw", 16'(reg_write_m), 16'h0);

    // Partial flag writes
    set_flags(4'b1111);
    issue(1, 0, 1, 4'hE, 2'b10, 0, 0, 0, 0, 4'b0000); tick();
    chk("nz_only", 16'(flags_q), 16'h3);
    issue(1, 0, 1, 4'hE, 2'b01, 0, 0, 0, 0, 4'b0000); tick();
    chk("cv_only", 16'(flags_q), 16'h0);

    // Signed compares
    set_flags(4'b1001);
    issue(0, 0, 1, 4'hA, 2'b00, 0, 0, 0, 0, 4'h0); chk("ge_1001", 16'(cond_ex_e), 16'h1);
    issue(0, 0, 1, 4'hB, 2'b00, 0, 0, 0, 0, 4'h0); chk("lt_1001", 16'(cond_ex_e), 16'h0);
    issue(0, 0, 1, 4'hC, 2'b00, 0, 0, 0, 0, 4'h0); chk("gt_1001", 16'(cond_ex_e), 16'h1);
    set_flags(4'b1000);
    issue(0, 0, 1, 4'hB, 2'b00, 0, 0, 0, 0, 4'h0); chk("lt_1000", 16'(cond_ex_e), 16'h1);
    issue(0, 0, 1, 4'hD, 2'b00, 0, 0, 0, 0, 4'h0); chk("le_1000", 16'(cond_ex_e), 16'h1);

    // Predicated-off flag setter
    set_flags(4'b0100);
    issue(1, 0, 1, 4'h1, 2'b11, 1, 1, 1, 0, 4'b1010);
    chk("ne_pc_src_e", 16'(pc_src_e), 16'h0);
    tick();
    chk("predoff_flags", 16'(flags_q), 16'h4);
    chk("predoff_outs", 16'({reg_write_m, mem_write_m, pc_src_m, undef_m}), 16'h0);

    // Stall with flush bubbles; plain stall holds
    issue(1, 0, 1, 4'hE, 2'b00, 1, 1, 1, 0, 4'h0); tick();
    chk("pre_flush_outs", 16'({reg_write_m, mem_write_m, pc_src_m}), 16'h7);
    issue(0, 1, 1, 4'hE, 2'b11, 1, 1, 1, 0, 4'hF); tick();
    chk("stall_flush_outs", 16'({reg_write_m, mem_write_m, pc_src_m, undef_m}), 16'h0);
    chk("stall_flush_flags", 16'(flags_q), 16'h4);
    issue(1, 0, 1, 4'hE, 2'b00, 1, 0, 1, 0, 4'h0); tick();
    issue(0, 0, 1, 4'hE, 2'b11, 0, 1, 0, 0, 4'hB);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_outs", 16'({reg_write_m, mem_write_m, pc_src_m, undef_m}), 16'hA);
      chk("stall_hold_flags", 16'(flags_q), 16'h4);
    end

    // Undefined condition
    sq0 = squash_cnt;
    issue(1, 0, 1, 4'hF, 2'b11, 1, 0, 0, 0, 4'hF); tick();
    chk("nv_undef", 16'(undef_m), 16'h1);
    chk("nv_regw",  16'(reg_write_m), 16'h0);
`ifdef COND_STATS_EN
    chk("nv_squash_inc", squash_cnt, sq0 + 16'd1);
`else
    chk("nv_squash_tied", squash_cnt, 16'h0);
`endif

    // Randomized phase, occasional mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end
      issue($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) != 0,
            4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) == 0, 4'($urandom));
      tick();
    end

`ifdef COND_STATS_EN
    for (int i = 0; i < 65540; i++) begin
      issue(1, 0, 1, 4'hE, 2'b00, 1, 0, 0, 0, 4'h0);
      tick();
    end
    chk("exec_saturate", exec_cnt, 16'hFFFF);
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_cond_flags.md
# ex_cond_flags

Execute-stage condition and flag block for the pipelined ARM-subset CPU. It holds the architectural NZCV flag register and evaluates each Execute-stage instruction's condition field against the registered flags. It updates the flags from the ALU under per-field write enables and gates the instruction's write/branch controls into the Execute→Memory pipeline register. It sits between the decoder's registered controls plus the ALU on the input side and the Memory stage on the output side.

## Interface
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  stage advance; 0 holds flags, output registers and counters.
- flush_e  in  1  kills the instruction currently in Execute.
- valid_e  in  1  Execute holds a real instruction.
- cond_e  in  4  ARM condition field.
- flag_w_e  in  2  [1] writes N,Z; [0] writes C,V.
- reg_w_e, mem_w_e, pcs_e  in  1 each  unconditional register-write, memory-write and PC-source controls.
- no_write_e  in  1  compare-type instruction; suppresses register write.
- alu_flags_e  in  4  {N,Z,C,V} from the ALU for this instruction.
- cond_ex_e  out  1  combinational condition-passed signal, qualified by valid_e.
- pc_src_e  out  1  combinational, pcs_e & cond_ex_e & ~flush_e; early branch redirect.
- flags_q  out  4  registered NZCV.
- reg_write_m, mem_write_m, pc_src_m, undef_m  out  1 each  registered gated controls.
- exec_cnt, squash_cnt  out  16 each  statistics counters (see Configuration).

## Operation
- Flag decode: ge = (N==V).
- Condition codes 0000–1110 follow the ARM table: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
- Condition 1111 is undefined: cond_ex_e=0 and undef_m=1 is registered for that instruction.
- Conditions are always evaluated against flags_q, never against alu_flags_e.
- cond_ex_e = valid_e & pass(cond_e, flags_q).
- Live instruction: en & valid_e & ~flush_e.
- Flag update, at the clock edge, for a live instruction with cond_ex_e=1:
  - flag_w_e[1] loads N,Z from alu_flags_e[3:2].
  - flag_w_e[0] loads C,V from alu_flags_e[1:0].
  - The two fields are independent.
  - No update otherwise.
- Output register update when en=1 and flush_e=0:
  - reg_write_m = reg_w_e & ~no_write_e & cond_ex_e.
  - mem_write_m = mem_w_e & cond_ex_e.
  - pc_src_m = pcs_e & cond_ex_e.
  - undef_m = valid_e & (cond_e==4'b1111).
- flush_e=1 loads a bubble (all four outputs 0) regardless of en.
- flush_e has priority over en=0, so a stalled-and-flushed stage still bubbles.
- en=0 with flush_e=0: outputs and flags hold.

## Timing
- Reset, asynchronous and immediate: flags_q=RESET_FLAGS; reg_write_m, mem_write_m, pc_src_m, undef_m=0; counters=0.
- cond_ex_e and pc_src_e: zero latency, combinational from cond_e, valid_e, flush_e and flags_q.
- Registered outputs and flags: one cycle latency.
- Back-to-back flag dependency: a flag-setting instruction at edge k makes its flags visible to the next instruction's condition in cycle k+1. No bypass is needed.
- Reset mid-stream: the instruction in flight is discarded with no flag write.
- Simultaneous flush_e and flag write: no flag write occurs.

## Configuration
- COND_STATS_EN defined, counters enabled:
  - exec_cnt increments on each live instruction with cond_ex_e=1.
  - squash_cnt increments on each live instruction with cond_ex_e=0, including 1111.
  - Both are 16-bit, saturate at 16'hFFFF and hold during en=0.
- COND_STATS_EN undefined: no counter logic; exec_cnt and squash_cnt are tied to 0.

## Test plan
- Reset sets flags_q=4'b0000. CMP-style (flag_w=11, cond=1110, alu_flags=0100) gives flags_q=0100 next cycle and reg_write_m=0. A following EQ instruction with reg_w=1 gives reg_write_m=1; an NE instruction gives 0.
- Partial write: flags_q=1111, flag_w=10, alu_flags=0000 → flags_q=0011. Then flag_w=01, alu_flags=0000 → flags_q=0000.
- Signed compares: flags_q=1001 (N=V) gives GE=1, LT=0, GT=1. flags_q=1000 gives LT=1, LE=1.
- Predicated-off flag setter: cond=NE with Z=1, flag_w=11, alu_flags=1010 → flags_q unchanged and all outputs 0.
- Flush/stall: en=0 with flush_e=1 → registered outputs 0 and flags_q unchanged. en=0 with flush_e=0 → outputs hold for 3 cycles.
- cond=1111 with valid_e=1 → undef_m=1, reg_write_m=0; with COND_STATS_EN, squash_cnt increments by 1. After 65 540 executed instructions, exec_cnt=16'hFFFF.
